// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
//   I2C target that ACKs its 7-bit address, takes writes into a small byte
//   register file and returns read data. The register file is addressed by an
//   auto-incrementing pointer. The first byte written after the address loads
//   the pointer; later bytes are stored at the pointer.
//   SDA is open-drain: the pad is driven low when SDA_PADOEN_O=0 and released
//   when it is 1. There is no clock stretching.
// Ports
//   WB_CLK_I      system clock
//   ARST_I        asynchronous reset, active low
//   SCL_PAD_I     resolved SCL line
//   SDA_PAD_I     resolved SDA line
//   SDA_PAD_O     SDA output value, tied to 0
//   SDA_PADOEN_O  SDA output enable, active low
//   BUSY_O        set by START, cleared by STOP
//   WR_STROBE_O   one-cycle pulse per stored data byte
//   WR_ADDR_O     register index of the last stored byte
//   WR_DATA_O     last stored byte
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         MEM_DEPTH   = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         WB_CLK_I,
  input  logic                         ARST_I,
  input  logic                         SCL_PAD_I,
  input  logic                         SDA_PAD_I,
  output logic                         SDA_PAD_O,
  output logic                         SDA_PADOEN_O,
  output logic                         BUSY_O,
  output logic                         WR_STROBE_O,
  output logic [$clog2(MEM_DEPTH)-1:0] WR_ADDR_O,
  output logic [7:0]                   WR_DATA_O
);
  localparam int PW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_e;

  // ---------------- input conditioning ----------------
  // The chains reset to 1 (idle bus) so that releasing reset does not create
  // a spurious edge or START.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;

  always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
    if (!ARST_I) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL_PAD_I};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA_PAD_I};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s &  scl_hist_q;
  assign start_det =  scl_s &  sda_hist_q & ~sda_s;
  assign stop_det  =  scl_s & ~sda_hist_q &  sda_s;

  // ---------------- state ----------------
  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            first_q, first_d;
  logic            rw_q, rw_d;
  logic            oen_q, oen_d;
  logic            busy_q, busy_d;
  logic            wr_stb_q, wr_stb_d;
  logic [PW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      mem_q [MEM_DEPTH];
  logic            mem_we;
  logic [7:0]      rx_byte;
  logic [PW-1:0]   ptr_inc;

  // Byte completed by the bit being sampled this cycle.
  assign rx_byte = {shift_q[6:0], sda_s};
  // Pointer width wraps MEM_DEPTH-1 to 0 for free.
  assign ptr_inc = ptr_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    rw_d      = rw_q;
    oen_d     = oen_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      oen_d     = 1'b1;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = rx_byte[0];
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        // oen_q tells the two falls apart: still released means this is the
        // fall after bit 8 (start ACK), driven means the ACK bit just ended.
        ADDR_ACK: if (scl_fall) begin
          if (oen_q) begin
            oen_d = 1'b0;
          end else if (rw_q) begin
            // Read: the MSB goes out on this same fall.
            state_d   = RD_BYTE;
            oen_d     = mem_q[ptr_q][7];
            shift_d   = {mem_q[ptr_q][6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end else begin
            state_d   = WR_BYTE;
            oen_d     = 1'b1;
            first_d   = 1'b1;
            bit_cnt_d = '0;
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d   = WR_ACK;
            bit_cnt_d = '0;
            if (first_q) begin
              ptr_d   = rx_byte[PW-1:0];
              first_d = 1'b0;
            end else begin
              mem_we    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_d     = ptr_inc;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (oen_q) begin
            oen_d = 1'b0;
          end else begin
            oen_d   = 1'b1;
            state_d = WR_BYTE;
          end
        end
        // bit_cnt counts bits already presented; the fall after the 8th
        // releases SDA for the master's ACK.
        RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            oen_d   = 1'b1;
            state_d = RD_ACK;
          end else begin
            oen_d     = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          ptr_d = ptr_inc;
          if (!sda_s) begin
            state_d   = RD_BYTE;
            shift_d   = mem_q[ptr_inc];
            bit_cnt_d = '0;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        default: ;  // IDLE, WAIT_STOP: wait for START/STOP
      endcase
    end
  end

  always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
    if (!ARST_I) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      first_q   <= 1'b0;
      rw_q      <= 1'b0;
      oen_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      rw_q      <= rw_d;
      oen_q     <= oen_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
    if (!ARST_I) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

  assign SDA_PAD_O    = 1'b0;
  assign SDA_PADOEN_O = oen_q;
  assign BUSY_O       = busy_q;
  assign WR_STROBE_O  = wr_stb_q;
  assign WR_ADDR_O    = wr_addr_q;
  assign WR_DATA_O    = wr_data_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master on an open-drain
// bus with pullup. Expected register writes are queued when the bytes are
// sent and popped by a monitor on WR_STROBE_O; ACKs and read data are
// compared against hand-computed values.
module tb_i2c_slave_responder;
  localparam int Q = 10;  // quarter SCL period in clocks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_o, sda_oen, busy, wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       sda_line;

  assign sda_line = m_sda & (sda_oen ? 1'b1 : sda_o);

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .WB_CLK_I     (clk),
    .ARST_I       (rst_n),
    .SCL_PAD_I    (m_scl),
    .SDA_PAD_I    (sda_line),
    .SDA_PAD_O    (sda_o),
    .SDA_PADOEN_O (sda_oen),
    .BUSY_O       (busy),
    .WR_STROBE_O  (wr_stb),
    .WR_ADDR_O    (wr_addr),
    .WR_DATA_O    (wr_data)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  logic [11:0] exp_wr_q [$];  // {addr, data}
  logic oen_low_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every strobe cycle must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_wr: addr %0h data %0h", wr_addr, wr_data);
      end else begin
        logic [11:0] e;
        e = exp_wr_q.pop_front();
        chk("wr_addr", {28'd0, wr_addr}, {28'd0, e[11:8]});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
    if (!sda_oen) oen_low_seen = 1'b1;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; clks(Q);
    m_scl = 1'b1; clks(2*Q);
    m_sda = 1'b0; clks(2*Q);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; clks(Q);
    m_scl = 1'b1; clks(2*Q);
    m_sda = 1'b1; clks(2*Q);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    m_sda = b;    clks(Q);
    m_scl = 1'b1; clks(Q);
    s = sda_line; clks(Q);
    m_scl = 1'b0; clks(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(~ack, s);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    clks(3);
    #1;
    chk("rst_oen", {31'd0, sda_oen}, 32'd1);
    chk("rst_pad_o", {31'd0, sda_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_waddr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wdata", {24'd0, wr_data}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    clks(5);

    // address match
    i2c_start();
    chk("match_busy", {31'd0, busy}, 32'd1);
    wbyte(8'hA0, ack); chk("match_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_oen", {31'd0, sda_oen}, 32'd1);

    // address miss: no ACK, SDA never driven, no writes
    oen_low_seen = 1'b0;
    i2c_start();
    wbyte(8'h90, ack); chk("miss_ack", {31'd0, ack}, 32'd0);
    wbyte(8'h03, ack); chk("miss_ack2", {31'd0, ack}, 32'd0);
    wbyte(8'h11, ack); chk("miss_ack3", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("miss_oen_low", {31'd0, oen_low_seen}, 32'd0);

    // write burst at pointer 3
    push_wr(4'd3, 8'h11);
    push_wr(4'd4, 8'h22);
    i2c_start();
    wbyte(8'hA0, ack); chk("wb_ack_a", {31'd0, ack}, 32'd1);
    wbyte(8'h03, ack); chk("wb_ack_p", {31'd0, ack}, 32'd1);
    wbyte(8'h11, ack); chk("wb_ack_d0", {31'd0, ack}, 32'd1);
    wbyte(8'h22, ack); chk("wb_ack_d1", {31'd0, ack}, 32'd1);
    i2c_stop();
    chk("wb_last_addr", {28'd0, wr_addr}, 32'd4);
    chk("wb_last_data", {24'd0, wr_data}, 32'h22);

    // mem[5] = 0x5A, used to verify the pointer after the combined read
    push_wr(4'd5, 8'h5A);
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h05, ack); wbyte(8'h5A, ack);
    chk("m5_ack", {31'd0, ack}, 32'd1);
    i2c_stop();

    // combined read with repeated START
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h03, ack);
    i2c_start();
    wbyte(8'hA1, ack); chk("cr_ack", {31'd0, ack}, 32'd1);
    rbyte(1'b1, d); chk("cr_d0", {24'd0, d}, 32'h11);
    rbyte(1'b0, d); chk("cr_d1", {24'd0, d}, 32'h22);
    chk("cr_nack_oen", {31'd0, sda_oen}, 32'd1);
    i2c_stop();
    // current-address read: pointer must have been left at 5
    i2c_start();
    wbyte(8'hA1, ack);
    rbyte(1'b0, d); chk("cr_ptr5", {24'd0, d}, 32'h5A);
    i2c_stop();

    // pointer wrap on write and read
    push_wr(4'd15, 8'hAA);
    push_wr(4'd0, 8'hBB);
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h0F, ack); wbyte(8'hAA, ack); wbyte(8'hBB, ack);
    chk("wrap_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h0F, ack);
    i2c_start();
    wbyte(8'hA1, ack);
    rbyte(1'b1, d); chk("wrap_d15", {24'd0, d}, 32'hAA);
    rbyte(1'b0, d); chk("wrap_d0", {24'd0, d}, 32'hBB);
    i2c_stop();

    // reset while the slave drives bit 6 (0) of 0xAA
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h0F, ack);
    i2c_start();
    wbyte(8'hA1, ack);
    bit_cycle(1'b1, ack); chk("rr_b7", {31'd0, ack}, 32'd1);
    m_sda = 1'b1; clks(Q);
    m_scl = 1'b1; clks(Q/2);
    #1;
    chk("rr_drive", {31'd0, sda_oen}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_oen", {31'd0, sda_oen}, 32'd1);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    m_sda = 1'b1;
    clks(5);
    @(negedge clk) rst_n = 1'b1;
    clks(5);
    chk("rr_waddr", {28'd0, wr_addr}, 32'd0);
    chk("rr_wdata", {24'd0, wr_data}, 32'd0);
    i2c_start();
    wbyte(8'hA1, ack); chk("rr_ack", {31'd0, ack}, 32'd1);
    rbyte(1'b0, d); chk("rr_ptr0", {24'd0, d}, 32'h00);
    i2c_stop();
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h0F, ack);
    i2c_start();
    wbyte(8'hA1, ack);
    rbyte(1'b0, d); chk("rr_mem15", {24'd0, d}, 32'h00);
    i2c_stop();

    clks(10);
    chk("wr_queue_empty", exp_wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
